// File: rtl/regfile_2r1w.sv
// Integer register file, 2 read / 1 write ports, x0 reads as zero, write-to-read bypass, busy scoreboard.
// Latency: write lands 1 edge later; reads are 0 cycles (RD_REG=0) or 1 cycle after an re=1 edge (RD_REG=1).
// Backpressure: none; every write and allocation is accepted in the cycle it is presented.
module regfile_2r1w #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5,
   parameter int RD_REG = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [XLEN-1:0]   wr_data,
   input  logic              re,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]   rd1,
   output logic [XLEN-1:0]   rd2,
   input  logic              alloc_en,
   input  logic [ADDR_W-1:0] alloc_addr,
   output logic              rs1_busy,
   output logic              rs2_busy
);

   localparam int NREG = 2 ** ADDR_W;

   logic [XLEN-1:0] regs_q [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [XLEN-1:0] byp1;
   logic [XLEN-1:0] byp2;
   logic [XLEN-1:0] rd1_q;
   logic [XLEN-1:0] rd2_q;
   logic            wr_live;

   // A write to x0 is discarded everywhere, so qualify it once.
   assign wr_live = we && (wr_addr != '0);

   // Storage update; entry 0 is never written so it stays at its reset value of 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_live) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   // Bypassed read values: x0 forced to zero, then the in-flight write, then storage.
   always_comb begin
      byp1 = regs_q[rs1_addr];
      byp2 = regs_q[rs2_addr];
      if (we && (wr_addr == rs1_addr)) byp1 = wr_data;
      if (we && (wr_addr == rs2_addr)) byp2 = wr_data;
      if (rs1_addr == '0) byp1 = '0;
      if (rs2_addr == '0) byp2 = '0;
   end

   // Next busy vector: clear on write first, so a same-cycle allocation to the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (we) busy_d[wr_addr] = 1'b0;
      if (alloc_en && (alloc_addr != '0)) busy_d[alloc_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Registered read path, captured only on re; unused (and trimmed) when RD_REG=0.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd1_q <= '0;
         rd2_q <= '0;
      end else if (re) begin
         rd1_q <= byp1;
         rd2_q <= byp2;
      end
   end

   assign rd1 = (RD_REG != 0) ? rd1_q : byp1;
   assign rd2 = (RD_REG != 0) ? rd2_q : byp2;

   // A result being written now is already visible through the bypass, so it is not busy.
   assign rs1_busy = busy_q[rs1_addr] & ~(we && (wr_addr == rs1_addr));
   assign rs2_busy = busy_q[rs2_addr] & ~(we && (wr_addr == rs2_addr));

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: one combinational-read and one registered-read instance share stimulus.
// Inputs change on the falling edge; outputs are sampled 1 time unit after a falling or rising edge.
// Expected values are hand-computed constants.
module tb_regfile_2r1w;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        re;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        alloc_en;
   logic [4:0]  alloc_addr;
   logic [31:0] rd1_c, rd2_c, rd1_r, rd2_r;
   logic        b1_c, b2_c, b1_r, b2_r;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_2r1w #(.XLEN(32), .ADDR_W(5), .RD_REG(0)) u_comb (
      .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .re(re),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd1(rd1_c), .rd2(rd2_c),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .rs1_busy(b1_c), .rs2_busy(b2_c)
   );

   regfile_2r1w #(.XLEN(32), .ADDR_W(5), .RD_REG(1)) u_reg (
      .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .re(re),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd1(rd1_r), .rd2(rd2_r),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .rs1_busy(b1_r), .rs2_busy(b2_r)
   );

   task automatic idle();
      we = 1'b0; wr_addr = '0; wr_data = '0; re = 1'b0;
      alloc_en = 1'b0; alloc_addr = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; idle(); rs1_addr = '0; rs2_addr = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0; re = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
         #1;
         total++; if (rd1_c !== 32'h0) begin bad++; $display("FAIL reset_rd1_comb a=%0d got=%h exp=%h", i, rd1_c, 32'h0); end
         total++; if (rd2_c !== 32'h0) begin bad++; $display("FAIL reset_rd2_comb a=%0d got=%h exp=%h", i, rd2_c, 32'h0); end
         total++; if ({b1_c, b2_c, b1_r, b2_r} !== 4'b0) begin bad++; $display("FAIL reset_busy a=%0d got=%b exp=0000", i, {b1_c, b2_c, b1_r, b2_r}); end
         @(posedge clk); #1;
         total++; if (rd1_r !== 32'h0 || rd2_r !== 32'h0) begin bad++; $display("FAIL reset_rd_reg a=%0d got=%h/%h exp=0/0", i, rd1_r, rd2_r); end
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      idle(); we = 1'b1; wr_addr = 5'd1; wr_data = 32'h0000_0004;
      @(negedge clk);
      wr_addr = 5'd2; wr_data = 32'h0000_0001;
      @(negedge clk);
      idle(); re = 1'b1; rs1_addr = 5'd1; rs2_addr = 5'd2;
      #1;
      total++; if (rd1_c !== 32'h4 || rd2_c !== 32'h1) begin bad++; $display("FAIL wr_rd_comb got=%h/%h exp=00000004/00000001", rd1_c, rd2_c); end
      @(posedge clk); #1;
      total++; if (rd1_r !== 32'h4 || rd2_r !== 32'h1) begin bad++; $display("FAIL wr_rd_reg got=%h/%h exp=00000004/00000001", rd1_r, rd2_r); end
   endtask

   task automatic test_x0();
      @(negedge clk);
      idle(); we = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF; re = 1'b1;
      rs1_addr = 5'd0; rs2_addr = 5'd1;
      #1;
      total++; if (rd1_c !== 32'h0) begin bad++; $display("FAIL x0_same_comb got=%h exp=00000000", rd1_c); end
      @(posedge clk); #1;
      total++; if (rd1_r !== 32'h0) begin bad++; $display("FAIL x0_same_reg got=%h exp=00000000", rd1_r); end
      @(negedge clk);
      we = 1'b0;
      #1;
      total++; if (rd1_c !== 32'h0) begin bad++; $display("FAIL x0_next_comb got=%h exp=00000000", rd1_c); end
      @(posedge clk); #1;
      total++; if (rd1_r !== 32'h0) begin bad++; $display("FAIL x0_next_reg got=%h exp=00000000", rd1_r); end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      idle(); we = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678; re = 1'b1;
      rs1_addr = 5'd5; rs2_addr = 5'd5;
      #1;
      total++; if (rd1_c !== 32'h1234_5678 || rd2_c !== 32'h1234_5678) begin bad++; $display("FAIL byp_comb got=%h/%h exp=12345678", rd1_c, rd2_c); end
      @(posedge clk); #1;
      total++; if (rd1_r !== 32'h1234_5678 || rd2_r !== 32'h1234_5678) begin bad++; $display("FAIL byp_reg got=%h/%h exp=12345678", rd1_r, rd2_r); end
      @(negedge clk);
      re = 1'b0; wr_data = 32'h0BAD_F00D;
      #1;
      total++; if (rd1_c !== 32'h0BAD_F00D) begin bad++; $display("FAIL byp2_comb got=%h exp=0badf00d", rd1_c); end
      @(posedge clk); #1;
      total++; if (rd1_r !== 32'h1234_5678 || rd2_r !== 32'h1234_5678) begin bad++; $display("FAIL hold_reg got=%h/%h exp=12345678", rd1_r, rd2_r); end
      @(negedge clk);
      we = 1'b0;
      #1;
      total++; if (rd2_c !== 32'h0BAD_F00D) begin bad++; $display("FAIL stored_x5 got=%h exp=0badf00d", rd2_c); end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      idle(); alloc_en = 1'b1; alloc_addr = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd9;
      #1;
      total++; if (b1_c !== 1'b0) begin bad++; $display("FAIL busy_not_yet got=%b exp=0", b1_c); end
      @(negedge clk);
      alloc_addr = 5'd9;
      #1;
      total++; if (b1_c !== 1'b1 || b1_r !== 1'b1) begin bad++; $display("FAIL busy_set got=%b/%b exp=1/1", b1_c, b1_r); end
      total++; if (b2_c !== 1'b0) begin bad++; $display("FAIL busy_x9_early got=%b exp=0", b2_c); end
      @(negedge clk);
      alloc_en = 1'b0; we = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
      #1;
      total++; if (b1_c !== 1'b0 || rd1_c !== 32'hA5A5_A5A5) begin bad++; $display("FAIL busy_wr_clear got=%b/%h exp=0/a5a5a5a5", b1_c, rd1_c); end
      total++; if (b2_c !== 1'b1) begin bad++; $display("FAIL busy_x9 got=%b exp=1", b2_c); end
      @(negedge clk);
      we = 1'b0;
      #1;
      total++; if (b1_c !== 1'b0) begin bad++; $display("FAIL busy_stays_clear got=%b exp=0", b1_c); end
      @(negedge clk);
      alloc_en = 1'b1; alloc_addr = 5'd7; we = 1'b1; wr_addr = 5'd7; wr_data = 32'h1111_1111;
      @(negedge clk);
      idle();
      #1;
      total++; if (b1_c !== 1'b1 || b1_r !== 1'b1) begin bad++; $display("FAIL busy_set_wins got=%b/%b exp=1/1", b1_c, b1_r); end
      @(negedge clk);
      alloc_en = 1'b1; alloc_addr = 5'd0; rs2_addr = 5'd0; we = 1'b1; wr_addr = 5'd9; wr_data = 32'h9;
      @(negedge clk);
      idle();
      #1;
      total++; if (b2_c !== 1'b0) begin bad++; $display("FAIL busy_x0 got=%b exp=0", b2_c); end
      rs2_addr = 5'd9;
      #1;
      total++; if (b2_c !== 1'b0) begin bad++; $display("FAIL busy_x9_cleared got=%b exp=0", b2_c); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      idle(); we = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
      alloc_en = 1'b1; alloc_addr = 5'd3; rs1_addr = 5'd3;
      @(negedge clk);
      idle();
      #1;
      total++; if (b1_c !== 1'b1 || rd1_c !== 32'h33) begin bad++; $display("FAIL pre_reset got=%b/%h exp=1/00000033", b1_c, rd1_c); end
      @(negedge clk);
      reset = 1'b1; we = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF; re = 1'b1;
      alloc_en = 1'b1; alloc_addr = 5'd3;
      @(negedge clk);
      reset = 1'b0; idle(); re = 1'b1;
      #1;
      total++; if (rd1_c !== 32'h0 || b1_c !== 1'b0) begin bad++; $display("FAIL post_reset_comb got=%h/%b exp=0/0", rd1_c, b1_c); end
      total++; if (rd1_r !== 32'h0 || b1_r !== 1'b0) begin bad++; $display("FAIL post_reset_regout got=%h/%b exp=0/0", rd1_r, b1_r); end
      @(posedge clk); #1;
      total++; if (rd1_r !== 32'h0) begin bad++; $display("FAIL post_reset_reg got=%h exp=00000000", rd1_r); end
   endtask

   initial begin
      reset = 1'b1; idle(); rs1_addr = '0; rs2_addr = '0;
      test_reset();
      test_write_read();
      test_x0();
      test_bypass();
      test_scoreboard();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised integer register file for the RV32I core: two read ports, one write port, x0 hardwired to zero, and same-cycle write-to-read bypass. Read data is either combinational or registered, selected by parameter, so the same block serves the non-pipelined and pipelined datapaths. A per-register busy scoreboard tracks in-flight writes for the pipeline's hazard logic.

## Interface
- XLEN, 32, data width in bits
- ADDR_W, 5, register address width; register count NREG = 2**ADDR_W
- RD_REG, 0, 0 = combinational read, 1 = registered read gated by re

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- we  input  1  write enable
- wr_addr  input  ADDR_W  write address
- wr_data  input  XLEN  write data
- re  input  1  read enable; used only when RD_REG=1
- rs1_addr  input  ADDR_W  read port 1 address
- rs2_addr  input  ADDR_W  read port 2 address
- rd1  output  XLEN  read port 1 data
- rd2  output  XLEN  read port 2 data
- alloc_en  input  1  marks alloc_addr as the destination of an issued instruction
- alloc_addr  input  ADDR_W  destination register being allocated
- rs1_busy  output  1  rs1_addr has a pending, not-yet-written result
- rs2_busy  output  1  rs2_addr has a pending, not-yet-written result

## Operation
- Storage: NREG x XLEN registers. Entry 0 is never written and always reads as 0.
- Write: on the clock edge with we=1 and wr_addr!=0, reg[wr_addr] <= wr_data. When wr_addr=0, the write is dropped.
- Bypassed read value for port n (byp_n):
  - 0 when rsn_addr=0;
  - otherwise wr_data when we=1 and wr_addr=rsn_addr;
  - otherwise reg[rsn_addr].
- RD_REG=0: rd1/rd2 = byp_1/byp_2 combinationally. re is ignored.
- RD_REG=1: on the clock edge with re=1, rd1 <= byp_1 and rd2 <= byp_2. With re=0, rd1/rd2 hold their values.
- Scoreboard: busy[NREG-1:0].
  - Set: alloc_en=1 and alloc_addr!=0 sets busy[alloc_addr].
  - Clear: we=1 clears busy[wr_addr].
  - Same address, same cycle for alloc and write: set wins, so busy stays 1 (a newer producer is in flight).
  - busy[0] is constant 0.
- rsn_busy = busy[rsn_addr] & ~(we & wr_addr==rsn_addr). A result being written this cycle is visible through the bypass, so it is not reported busy.
- Both read ports may address the same register; each port is independent.

## Timing
- Reset (reset=1 at an edge) clears:
  - all registers to 0;
  - all busy bits to 0;
  - registered rd1/rd2 to 0 when RD_REG=1.
- Reset takes priority over we, re and alloc_en in the same cycle.
- Combinational outputs are 0 after reset because all storage is 0.
- Reset asserted mid-operation discards all pending writes and allocations; nothing is written that cycle.
- Write latency: 1 edge into storage. The same-cycle read sees wr_data through the bypass.
- Read latency:
  - RD_REG=0: 0 cycles.
  - RD_REG=1: 1 cycle after the re=1 edge, with the bypass applied at that edge.
- Scoreboard latency: a busy bit becomes visible on rsn_busy the cycle after alloc_en. It drops combinationally in the cycle the matching write occurs.
- Every address value is a legal index (NREG = 2**ADDR_W), so there is no out-of-range case.

## Test plan
- Reset then read all 32 addresses on both ports -> every rd1/rd2 = 0x00000000, rs1_busy = rs2_busy = 0.
- Write x1=0x00000004, then x2=0x00000001; next cycle read rs1=1, rs2=2 -> rd1=0x00000004, rd2=0x00000001.
- we=1, wr_addr=0, wr_data=0xDEADBEEF; read rs1=0 in the same and the following cycle -> rd1=0 both cycles.
- we=1, wr_addr=5, wr_data=0x12345678, rs1_addr=rs2_addr=5 in the same cycle:
  - RD_REG=0 -> rd1=rd2=0x12345678 in that cycle;
  - RD_REG=1 with re=1 -> rd1=rd2=0x12345678 after the edge;
  - a following cycle with re=0 and a new write to x5 -> outputs hold 0x12345678.
- alloc_en with alloc_addr=7, then rs1_addr=7 -> rs1_busy=1.
  - we to x7 with 0xA5A5A5A5 -> in that cycle rs1_busy=0 and rd1=0xA5A5A5A5.
  - Repeat with simultaneous alloc_en and we on x7 -> rs1_busy=1 on the next cycle.
- Write and allocate x3, then assert reset together with we to x3 (0xFFFFFFFF) -> next cycle x3 reads 0 and rs1_busy=0.
